modexp_ctrl: RTL and testbench
==============================

// Module: modexp_ctrl
// PURPOSE
//  Sequencer for RSA decryption m = c^d mod n using left-to-right square-and-multiply.
//  Drives the shared external modular multiplier (mod_mult) over a start/done handshake.
//  Sits between the PRU instruction decoder and mod_mult and owns the accumulator.
//  One exponentiation runs at a time.
// PARAMETERS
//  WIDTH  32  width of base, modulus, result and multiplier operands
//  EXP_W  32  exponent width; bit index counter is $clog2(EXP_W) bits
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  start       in   1      request; sampled only in IDLE
//  base        in   WIDTH  ciphertext c; latched on accepted start
//  exp         in   EXP_W  private exponent d; latched on accepted start
//  modulus     in   WIDTH  n; latched on accepted start
//  busy        out  1      high from cycle after accepted start until done
//  done        out  1      one-cycle pulse; result/err valid from this cycle
//  err         out  1      modulus==0 on the last run; held until next start
//  result      out  WIDTH  c^d mod n; held until next accepted start
//  mul_start   out  1      one-cycle pulse to mod_mult
//  mul_a       out  WIDTH  multiplier operand A; stable from mul_start to mul_done
//  mul_b       out  WIDTH  multiplier operand B; stable from mul_start to mul_done
//  mul_mod     out  WIDTH  latched modulus
//  mul_done    in   1      one-cycle pulse from mod_mult; ignored unless in a WAIT state
//  mul_result  in   WIDTH  (mul_a*mul_b) mod mul_mod; valid with mul_done
// BEHAVIOUR
//  Reset (async assert, sync-deassert upstream):
//   - state=IDLE; busy, done, err, mul_start = 0.
//   - result, mul_a, mul_b, mul_mod = 0.
//   - Reset mid-run aborts with no done pulse; mod_mult shares rst_n.
//  FSM: IDLE, PREP_REQ, PREP_WAIT, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FIN.
//  IDLE:
//   - On start, latch operands.
//   - modulus==0: err=1, result=0, go FIN.
//   - exp==0: result = (modulus==1) ? 0 : 1, go FIN; no multiplier ops.
//   - Else: idx = leading-one index of exp, go PREP_REQ.
//  PREP_REQ/PREP_WAIT:
//   - Issue base*1 to reduce base below n; store the product as Bred.
//   - Store the product in acc as well; the top set bit is consumed.
//   - If idx==0, go FIN; else idx--, go SQR_REQ.
//  SQR_REQ/SQR_WAIT:
//   - Issue acc*acc; on mul_done, acc = mul_result.
//   - If exp[idx]==1, go MUL_REQ; else go to the next-bit step.
//  MUL_REQ/MUL_WAIT:
//   - Issue acc*Bred; on mul_done, acc = mul_result; go to the next-bit step.
//  Next-bit step: if idx==0, go FIN; else idx--, go SQR_REQ.
//  FIN: result = acc (unless set in IDLE), done=1 for one cycle, busy=0, go IDLE.
//  Handshake:
//   - mul_start pulses exactly one cycle in each *_REQ state.
//   - The next REQ starts no earlier than the cycle after mul_done.
//   - A mul_done arriving in the same cycle as mul_start is accepted.
//  start while busy is ignored; no queueing. start in the FIN cycle is also ignored.
//  Multiplier operation count = 1 + (pos_of_top_one) + (popcount(exp) - 1).
//  Latency = 2 + sum of multiplier latencies + 1 cycle per op; exp==0 or n==0 takes 2 cycles.
//  base >= n is legal (handled by PREP).
//  Arithmetic: all products are formed by mod_mult; the controller does no wide math.
// STRUCTURE
//  rsa_pkg: modexp_state_t enum; default WIDTH/EXP_W localparams; one-constant typedef for the operand vector.
//  Sub-module lead_one_det (combinational priority encoder, EXP_W -> $clog2(EXP_W)).
//  lead_one_det gives idx in the start cycle, with no scan cycles.
//  mod_mult stays external so the PRU can share it.
// TESTING
//  Bench uses a behavioural mod_mult with random 1..8 cycle latency.
//  - base=4, exp=13, n=497: result=445, done once, exactly 6 mul_start pulses (1 prep, 3 sqr, 2 mul).
//  - base=10, exp=1, n=7: result=3 after 1 multiplier op; base=3, exp=0, n=7: result=1, 0 ops, done 2 cycles after start.
//  - n=1, exp=5: result=0, err=0; n=0: err=1, result=0, no mul_start.
//  - Pulse start with new operands while busy: ignored; result still matches the first operand set; busy never drops early.
//  - Assert rst_n low during SQR_WAIT: busy/mul_start/done go 0 immediately; no done; the next run (4,13,497) still returns 445.
//  - Random 32-bit c, d, n>1 (500 runs) vs reference model; check mul_a/mul_b stable while waiting.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types for the RSA exponentiation sequencer: FSM encoding, default
// operand widths and the operand vector type.
package rsa_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int EXP_W_DEF = 32;

    typedef logic [WIDTH_DEF-1:0] operand_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP_REQ,
        S_PREP_WAIT,
        S_SQR_REQ,
        S_SQR_WAIT,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_FIN
    } modexp_state_t;

endpackage

// File: rtl/lead_one_det.sv
// Combinational priority encoder: index of the most significant set bit.
// Returns 0 for an all-zero input; callers screen that case themselves.
module lead_one_det #(
    parameter int IN_W  = 32,
    parameter int IDX_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  vec_i,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod modulus
// by driving an external shared modular multiplier over a start/done handshake.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_mod,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result
);

    localparam int IDX_W = $clog2(EXP_W);

    modexp_state_t    state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] bred_q, bred_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] lead_idx;
    logic             step_next;

    lead_one_det #(
        .IN_W  (EXP_W),
        .IDX_W (IDX_W)
    ) u_lead_one_det (
        .vec_i (exp),
        .idx_o (lead_idx)
    );

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        bred_d    = bred_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        result_d  = result_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        step_next = 1'b0;
        mul_start = (state_q == S_PREP_REQ) || (state_q == S_SQR_REQ) ||
                    (state_q == S_MUL_REQ);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    exp_d  = exp;
                    mod_d  = modulus;
                    if (modulus == '0) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = S_FIN;
                    end else if (exp == '0) begin
                        acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_d = S_FIN;
                    end else begin
                        // base*1 mod n reduces an oversized base before the loop
                        idx_d   = lead_idx;
                        mul_a_d = base;
                        mul_b_d = WIDTH'(1);
                        state_d = S_PREP_REQ;
                    end
                end
            end
            S_PREP_REQ, S_PREP_WAIT: begin
                if (mul_done) begin
                    bred_d    = mul_result;
                    acc_d     = mul_result;
                    step_next = 1'b1;
                end else if (state_q == S_PREP_REQ) begin
                    state_d = S_PREP_WAIT;
                end
            end
            S_SQR_REQ, S_SQR_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (exp_q[idx_q]) begin
                        mul_a_d = mul_result;
                        mul_b_d = bred_q;
                        state_d = S_MUL_REQ;
                    end else begin
                        step_next = 1'b1;
                    end
                end else if (state_q == S_SQR_REQ) begin
                    state_d = S_SQR_WAIT;
                end
            end
            S_MUL_REQ, S_MUL_WAIT: begin
                if (mul_done) begin
                    acc_d     = mul_result;
                    step_next = 1'b1;
                end else if (state_q == S_MUL_REQ) begin
                    state_d = S_MUL_WAIT;
                end
            end
            S_FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The fresh product is the next square's operand on both ports
        if (step_next) begin
            if (idx_q == '0) begin
                state_d = S_FIN;
            end else begin
                idx_d   = idx_q - IDX_W'(1);
                mul_a_d = mul_result;
                mul_b_d = mul_result;
                state_d = S_SQR_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            exp_q    <= '0;
            mod_q    <= '0;
            bred_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            bred_q   <= bred_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign result  = result_q;
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign mul_mod = mod_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed and random checks of modexp_ctrl against a behavioural modular
// multiplier with random latency and an independent right-to-left reference.
module tb_modexp_ctrl;
    import rsa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base, exp, modulus;
    logic        busy, done, err;
    logic [31:0] result;
    logic        mul_start;
    logic [31:0] mul_a, mul_b, mul_mod;
    logic        mul_done = 1'b0;
    logic [31:0] mul_result = '0;

    int checks = 0;
    int errors = 0;

    // multiplier model state
    int       lat_max = 8;
    int       mm_ops = 0;
    int       mm_lat_sum = 0;
    int       mm_viol = 0;
    int       mm_cnt = 0;
    bit       mm_pend = 1'b0;
    operand_t cap_a, cap_b, cap_r;

    modexp_ctrl #(.WIDTH(32), .EXP_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base       (base),
        .exp        (exp),
        .modulus    (modulus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_mod    (mul_mod),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    // Behavioural mod_mult: samples mul_start on the falling edge, answers
    // 1..lat_max cycles later, and flags operand changes or re-starts while busy.
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (!rst_n) begin
            mm_pend = 1'b0;
        end else if (mm_pend) begin
            if (mul_a !== cap_a || mul_b !== cap_b || mul_start !== 1'b0) mm_viol++;
            mm_cnt--;
            if (mm_cnt == 0) begin
                mul_done   = 1'b1;
                mul_result = cap_r;
                mm_pend    = 1'b0;
            end
        end else if (mul_start === 1'b1) begin
            longint unsigned p;
            mm_ops++;
            cap_a = mul_a;
            cap_b = mul_b;
            p     = (64'(mul_a) * 64'(mul_b)) % 64'(mul_mod);
            cap_r = p[31:0];
            mm_cnt = $urandom_range(1, lat_max);
            mm_lat_sum += mm_cnt;
            mm_pend = 1'b1;
        end
    end

    function automatic operand_t ref_modexp(input operand_t c, input operand_t d, input operand_t n);
        longint unsigned r, b, m;
        if (n == 0) return '0;
        m = n;
        r = 1 % m;
        b = c % m;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r[31:0];
    endfunction

    function automatic int ref_ops(input operand_t d);
        int top = 0;
        int pop = 0;
        if (d == 0) return 0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                top = i;
                pop++;
            end
        end
        return 1 + top + (pop - 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One exponentiation; inj>0 pulses a competing start at that cycle.
    task automatic run(input string tag, input operand_t c, input operand_t d, input operand_t n,
                       input operand_t exp_r, input logic exp_e, input int exp_ops, input int inj);
        int  ops0, lat0, viol0, cyc;
        bit  busy_ok;
        ops0  = mm_ops;
        lat0  = mm_lat_sum;
        viol0 = mm_viol;
        base = c; exp = d; modulus = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 4000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == inj) begin
                base = 32'd5; exp = 32'd7; modulus = 32'd11; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 64'(done), 64'(1));
        chk({tag, " result"}, 64'(result), 64'(exp_r));
        chk({tag, " err"}, 64'(err), 64'(exp_e));
        chk({tag, " mul_ops"}, 64'(mm_ops - ops0), 64'(exp_ops));
        chk({tag, " latency"}, 64'(cyc), 64'(2 + (mm_lat_sum - lat0) + exp_ops));
        chk({tag, " busy_held"}, 64'(busy_ok), 64'(1));
        chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
        chk({tag, " handshake"}, 64'(mm_viol - viol0), 64'(0));
        chk({tag, " mul_mod"}, 64'(mul_mod), 64'(n));
        @(negedge clk);
        chk({tag, " done_pulse"}, 64'(done), 64'(0));
        chk({tag, " idle_after"}, 64'(busy), 64'(0));
        $display("run %s: c=%0d d=%0d n=%0d result=%0d err=%0d ops=%0d cycles=%0d",
                 tag, c, d, n, result, err, mm_ops - ops0, cyc);
    endtask

    initial begin
        int ops0, cyc;
        operand_t c, d, n;

        rst_n = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst err", 64'(err), 64'(0));
        chk("rst mul_start", 64'(mul_start), 64'(0));
        chk("rst result", 64'(result), 64'(0));
        chk("rst mul_a", 64'(mul_a), 64'(0));
        chk("rst mul_b", 64'(mul_b), 64'(0));
        chk("rst mul_mod", 64'(mul_mod), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run("4^13%497", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 6, 0);
        run("10^1%7", 32'd10, 32'd1, 32'd7, 32'd3, 1'b0, 1, 0);
        run("3^0%7", 32'd3, 32'd0, 32'd7, 32'd1, 1'b0, 0, 0);
        run("3^0%1", 32'd3, 32'd0, 32'd1, 32'd0, 1'b0, 0, 0);
        run("9^5%1", 32'd9, 32'd5, 32'd1, 32'd0, 1'b0, 4, 0);
        run("9^5%0", 32'd9, 32'd5, 32'd0, 32'd0, 1'b1, 0, 0);
        repeat (2) @(negedge clk);
        chk("err held", 64'(err), 64'(1));
        run("500^3%7", 32'd500, 32'd3, 32'd7, 32'd6, 1'b0, 3, 0);
        run("1^2^31%1000", 32'd1, 32'h8000_0000, 32'd1000, 32'd1, 1'b0, 32, 0);
        run("busy_start", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 6, 3);

        // Reset while the first square is outstanding
        ops0 = mm_ops;
        base = 32'd4; exp = 32'd13; modulus = 32'd497; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (mm_ops - ops0 < 2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort reached_sqr", 64'(mm_ops - ops0), 64'(2));
        @(negedge clk);
        chk("abort busy_before", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort mul_start", 64'(mul_start), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort done_in_rst", 64'(done), 64'(0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no_done", 64'(done), 64'(0));
        end
        $display("run abort: reset during square wait, busy=%0d done=%0d", busy, done);
        run("after_abort", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 6, 0);

        lat_max = 4;
        for (int k = 0; k < 500; k++) begin
            c = $urandom;
            d = $urandom >> $urandom_range(0, 31);
            n = $urandom;
            while (n < 2) n = $urandom;
            run($sformatf("rand%0d", k), c, d, n, ref_modexp(c, d, n), 1'b0, ref_ops(d), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
